// File: rtl/rv32m_pkg.sv
// Shared RV32M constants: divide func3 codes, divider state encoding and default XLEN.
package rv32m_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_t;

endpackage

// File: rtl/rv32m_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left, subtract divisor when it fits.
module rv32m_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   remIn,
    input  logic [XLEN-1:0] quoIn,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   remOut,
    output logic [XLEN-1:0] quoOut
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // One extra bit keeps the shifted remainder exact, so the compare never wraps.
    assign shifted = (remIn << 1) | {{XLEN{1'b0}}, quoIn[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = (shifted >= {1'b0, divisor});

    assign remOut = fits ? diff : shifted;
    assign quoOut = {quoIn[XLEN-2:0], fits};

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 RV32M DIV/DIVU/REM/REMU unit; all outputs registered.
// Define DIV_EARLY_OUT_EN to let b=0, signed overflow and non-divide codes bypass the iteration.
module rv32m_div_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] r,
    output logic            done,
    output logic            busy
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accepting edge
    // CALC  | one restoring step per edge, XLEN steps
    // FIX   | apply signs and ISA special cases, load r, raise done
    // DONE  | drop done and busy, return to IDLE

    localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN-1);

    divState_t       state;
    logic            isRemReg, isDivReg, negQ, negR, bZero, ovf;
    logic [XLEN-1:0] aReg, divisor, quo;
    logic [XLEN:0]   rem;
    logic [CNT_W-1:0] cnt;

    logic            isSigned, signA, signB, inBZero, inOvf;
    logic [XLEN-1:0] absA, absB, quoS, remS, fixRes, quoStep;
    logic [XLEN:0]   remStep;

    assign isSigned = ~func3[0];
    assign signA    = isSigned & a[XLEN-1];
    assign signB    = isSigned & b[XLEN-1];
    assign absA     = signA ? -a : a;
    assign absB     = signB ? -b : b;
    assign inBZero  = (b == '0);
    assign inOvf    = isSigned & (a == MIN_INT) & (&b);

    rv32m_div_step #(.XLEN(XLEN)) u_step (
        .remIn  (rem),
        .quoIn  (quo),
        .divisor(divisor),
        .remOut (remStep),
        .quoOut (quoStep)
    );

    assign quoS = negQ ? -quo : quo;
    assign remS = negR ? -rem[XLEN-1:0] : rem[XLEN-1:0];

    always_comb begin
        fixRes = isRemReg ? remS : quoS;
        if (!isDivReg)
            fixRes = '0;
        else if (bZero)
            fixRes = isRemReg ? aReg : '1;
        else if (ovf)
            fixRes = isRemReg ? '0 : MIN_INT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            r        <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
            isRemReg <= 1'b0;
            isDivReg <= 1'b0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
            bZero    <= 1'b0;
            ovf      <= 1'b0;
            aReg     <= '0;
            divisor  <= '0;
            quo      <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        isRemReg <= func3[1];
                        isDivReg <= func3[2];
                        negQ     <= signA ^ signB;
                        negR     <= signA;
                        bZero    <= inBZero;
                        ovf      <= inOvf;
                        aReg     <= a;
                        divisor  <= absB;
                        quo      <= absA;
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        state    <= (inBZero | inOvf | ~func3[2]) ? FIX : CALC;
`else
                        state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem <= remStep;
                    quo <= quoStep;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP)
                        state <= FIX;
                end
                FIX: begin
                    r     <= fixRes;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Scoreboard bench for rv32m_div_unit: driver queues expected results, a monitor checks each done pulse.
module tb_rv32m_div_unit;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] r;
    logic        done;
    logic        busy;

    localparam int LAT = 33;
`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_SP = 1;
`else
    localparam int LAT_SP = 33;
`endif

    rv32m_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .func3(func3),
        .a    (a),
        .b    (b),
        .r    (r),
        .done (done),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int edgeCnt = 0;
    always @(posedge clk) edgeCnt++;

    typedef struct {
        logic [31:0] r;
        int          lat;
        int          edgeAt;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_done: got done with r=%h, required no done", r);
            end else begin
                e = sb.pop_front();
                tests++;
                if (r !== e.r) begin
                    fails++;
                    $display("FAIL result_%0d: r=%h required %h", e.id, r, e.r);
                end
                tests++;
                if (edgeCnt - e.edgeAt != e.lat) begin
                    fails++;
                    $display("FAIL latency_%0d: %0d cycles required %0d", e.id, edgeCnt - e.edgeAt, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] expR, input int lat, input int id);
        exp_t item;
        @(negedge clk);
        start = 1'b1; func3 = f; a = aa; b = bb;
        @(posedge clk);
        #1;
        start = 1'b0; func3 = 3'b000; a = 32'hDEAD_BEEF; b = 32'h0;
        item.r = expR; item.lat = lat; item.edgeAt = edgeCnt; item.id = id;
        sb.push_back(item);
    endtask

    task automatic waitDone(input int id);
        int k;
        for (k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 80) begin
            tests++; fails++;
            $display("FAIL timeout_%0d: no done within 80 cycles, required done", id);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [31:0] expR;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{F3_DIVU, 32'd100,       32'd7,         32'd14,        LAT});
        vecs.push_back('{F3_REMU, 32'd100,       32'd7,         32'd2,         LAT});
        vecs.push_back('{F3_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT});
        vecs.push_back('{F3_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT});
        vecs.push_back('{F3_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, LAT});
        vecs.push_back('{F3_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         LAT});
        vecs.push_back('{F3_REMU, 32'hFFFF_FFFF, 32'h10,        32'hF,         LAT});
        vecs.push_back('{F3_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, LAT});
        vecs.push_back('{F3_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SP});
        vecs.push_back('{F3_REMU, 32'd5,         32'd0,         32'd5,         LAT_SP});
        vecs.push_back('{F3_REM,  32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, LAT_SP});
        vecs.push_back('{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP});
        vecs.push_back('{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SP});
        vecs.push_back('{3'b000,  32'd100,       32'd7,         32'd0,         LAT_SP});

        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("reset_r", r, 32'd0);
        checkVal("reset_done", {31'd0, done}, 32'd0);
        checkVal("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].f, vecs[i].aa, vecs[i].bb, vecs[i].expR, vecs[i].lat, i);
            waitDone(i);
        end

        // start pulses while busy must be ignored
        issue(F3_DIVU, 32'd100, 32'd7, 32'd14, LAT, 100);
        repeat (9) @(negedge clk);
        checkVal("busy_mid_op", {31'd0, busy}, 32'd1);
        start = 1'b1; func3 = F3_REMU; a = 32'd50; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        waitDone(100);

        // start during the DONE cycle is ignored, the next cycle's start is accepted
        start = 1'b1; func3 = F3_DIVU; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        issue(F3_DIVU, 32'd9, 32'd3, 32'd3, LAT, 101);
        @(negedge clk);
        checkVal("busy_after_accept", {31'd0, busy}, 32'd1);
        waitDone(101);
        @(negedge clk);
        checkVal("busy_after_done", {31'd0, busy}, 32'd0);

        // reset in the middle of an operation aborts it silently
        start = 1'b1; func3 = F3_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkVal("abort_busy", {31'd0, busy}, 32'd0);
        checkVal("abort_done", {31'd0, done}, 32'd0);
        checkVal("abort_r", r, 32'd0);
        rst = 1'b1;
        repeat (45) @(negedge clk);
        issue(F3_DIVU, 32'd9, 32'd3, 32'd3, LAT, 102);
        waitDone(102);

        repeat (3) @(negedge clk);
        checkVal("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
